// File: rtl/voice_alloc_pkg.sv
// rtl/voice_alloc_pkg.sv - shared types and constants for the voice allocator
//
// Purpose: FSM state encoding, the rest-note code and default bus widths used
//          by voice_allocator and voice_select.
// Ports:   none (package).

package voice_alloc_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      HOLD = 2'd2
   } state_e;

   localparam int REST_NOTE  = 0;
   localparam int DEF_NOTE_W = 6;
   localparam int DEF_DUR_W  = 6;

endpackage

// File: rtl/voice_select.sv
// rtl/voice_select.sv - combinational free-voice and oldest-voice finder
//
// Purpose: From the per-voice busy flags and age ranks, report whether any
//          voice is free, the lowest-index free voice, and the busy voice with
//          the highest rank (ties to the lowest index).
// Ports:
//   busy        in   per-voice busy flags
//   rank        in   per-voice age rank (higher = loaded longer ago)
//   free_found  out  at least one voice is free
//   free_idx    out  lowest-index free voice
//   oldest_idx  out  busy voice with maximum rank

module voice_select #(
   parameter int NUM_VOICES = 3,
   parameter int IDX_W      = $clog2(NUM_VOICES)
) (
   input  logic [NUM_VOICES-1:0]            busy,
   input  logic [NUM_VOICES-1:0][IDX_W-1:0] rank,
   output logic                             free_found,
   output logic [IDX_W-1:0]                 free_idx,
   output logic [IDX_W-1:0]                 oldest_idx
);

   logic [IDX_W-1:0] best_rank;
   logic             have_busy;

   always_comb begin
      free_found = 1'b0;
      free_idx   = '0;
      // Walk downwards so the last hit is the lowest index.
      for (int v = NUM_VOICES - 1; v >= 0; v--) begin
         if (!busy[v]) begin
            free_found = 1'b1;
            free_idx   = IDX_W'(v);
         end
      end
   end

   always_comb begin
      oldest_idx = '0;
      best_rank  = '0;
      have_busy  = 1'b0;
      // Strict compare keeps the lowest index on equal ranks.
      for (int v = 0; v < NUM_VOICES; v++) begin
         if (busy[v] && (!have_busy || rank[v] > best_rank)) begin
            have_busy  = 1'b1;
            best_rank  = rank[v];
            oldest_idx = IDX_W'(v);
         end
      end
   end

endmodule

// File: rtl/voice_allocator.sv
// rtl/voice_allocator.sv - assigns incoming notes to a pool of note_player voices
//
// Purpose: Accepts note requests over a valid/ready handshake, picks a target
//          voice, and drives a one-cycle load pulse plus shared note/duration
//          buses. Tracks per-voice busy flags and age ranks.
// Option:  define VOICE_STEAL_EN to steal the oldest busy voice when none is
//          free; otherwise requests stall until a voice frees.
// Ports:
//   clk, reset    clock and synchronous active-high reset
//   play_enable   global play gate
//   note_valid    request offered        note_ready  request accepted
//   note_in       requested note (0 = rest)
//   duration_in   requested duration in beats
//   voice_done    per-voice done_with_note
//   load_voice    one-hot load pulse per voice
//   note_out      registered shared note bus
//   duration_out  registered shared duration bus
//   voice_busy    per-voice busy flags

module voice_allocator
   import voice_alloc_pkg::*;
#(
   parameter int NUM_VOICES = 3,
   parameter int NOTE_W     = DEF_NOTE_W,
   parameter int DUR_W      = DEF_DUR_W
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  play_enable,
   input  logic                  note_valid,
   output logic                  note_ready,
   input  logic [NOTE_W-1:0]     note_in,
   input  logic [DUR_W-1:0]      duration_in,
   input  logic [NUM_VOICES-1:0] voice_done,
   output logic [NUM_VOICES-1:0] load_voice,
   output logic [NOTE_W-1:0]     note_out,
   output logic [DUR_W-1:0]      duration_out,
   output logic [NUM_VOICES-1:0] voice_busy
);

   localparam int               IDX_W    = $clog2(NUM_VOICES);
   localparam logic [IDX_W-1:0] MAX_RANK = IDX_W'(NUM_VOICES - 1);

   state_e                          state_q, state_d;
   logic [NOTE_W-1:0]               note_q;
   logic [DUR_W-1:0]                dur_q;
   logic [IDX_W-1:0]                target_q;
   logic [NUM_VOICES-1:0]           busy_q, busy_d;
   logic [NUM_VOICES-1:0][IDX_W-1:0] rank_q, rank_d;

   logic             free_found;
   logic [IDX_W-1:0] free_idx, oldest_idx, target_sel, old_rank;
   logic             target_avail, xfer, load_note;

   voice_select #(
      .NUM_VOICES (NUM_VOICES),
      .IDX_W      (IDX_W)
   ) u_select (
      .busy       (busy_q),
      .rank       (rank_q),
      .free_found (free_found),
      .free_idx   (free_idx),
      .oldest_idx (oldest_idx)
   );

   // Without stealing, oldest_idx is only chosen when note_ready is low,
   // so it never reaches a transfer.
   assign target_sel = free_found ? free_idx : oldest_idx;

`ifdef VOICE_STEAL_EN
   assign target_avail = 1'b1;
`else
   assign target_avail = free_found;
`endif

   assign xfer      = note_valid && note_ready;
   assign load_note = xfer && (note_in != NOTE_W'(REST_NOTE));

   // State register
   always_ff @(posedge clk) begin
      if (reset) state_q <= IDLE;
      else       state_q <= state_d;
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (load_note) state_d = LOAD;
         LOAD:    state_d = HOLD;
         HOLD:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Output logic
   always_comb begin
      note_ready = !reset && (state_q == IDLE) && play_enable && target_avail;
      load_voice = '0;
      if (state_q == LOAD && !reset) begin
         for (int v = 0; v < NUM_VOICES; v++)
            if (target_q == IDX_W'(v)) load_voice[v] = 1'b1;
      end
   end

   // Busy and rank bookkeeping
   always_comb begin
      busy_d   = busy_q;
      rank_d   = rank_q;
      old_rank = '0;
      if (play_enable) begin
         for (int v = 0; v < NUM_VOICES; v++) begin
            // Done from the voice being loaded is stale until after HOLD.
            if (voice_done[v] && !(state_q != IDLE && target_q == IDX_W'(v)))
               busy_d[v] = 1'b0;
         end
      end
      if (load_note) begin
         // A free voice counts as older than every busy one, so all busy
         // voices age when it is taken.
         old_rank = busy_q[target_sel] ? rank_q[target_sel] : MAX_RANK;
         for (int v = 0; v < NUM_VOICES; v++) begin
            if (busy_q[v] && rank_q[v] < old_rank)
               rank_d[v] = rank_q[v] + 1'b1;
         end
         rank_d[target_sel] = '0;
         busy_d[target_sel] = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         note_q   <= '0;
         dur_q    <= '0;
         target_q <= '0;
         busy_q   <= '0;
         rank_q   <= '0;
      end else begin
         busy_q <= busy_d;
         rank_q <= rank_d;
         if (load_note) begin
            note_q   <= note_in;
            dur_q    <= duration_in;
            target_q <= target_sel;
         end
      end
   end

   assign note_out     = note_q;
   assign duration_out = dur_q;
   assign voice_busy   = busy_q;

endmodule

// File: tb/tb_voice_allocator.sv
// tb/tb_voice_allocator.sv - directed self-checking bench for voice_allocator

module tb_voice_allocator;

   logic       clk = 1'b0;
   logic       reset, play_enable, note_valid, note_ready;
   logic [5:0] note_in, duration_in, note_out, duration_out;
   logic [2:0] voice_done, load_voice, voice_busy;

   int n_assert = 0;
   int n_fail   = 0;

   voice_allocator dut (
      .clk          (clk),
      .reset        (reset),
      .play_enable  (play_enable),
      .note_valid   (note_valid),
      .note_ready   (note_ready),
      .note_in      (note_in),
      .duration_in  (duration_in),
      .voice_done   (voice_done),
      .load_voice   (load_voice),
      .note_out     (note_out),
      .duration_out (duration_out),
      .voice_busy   (voice_busy)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic do_reset();
      reset = 1'b1;
      tick();
      reset = 1'b0;
   endtask

   initial begin
      reset = 1'b1; play_enable = 1'b1; note_valid = 1'b0;
      note_in = '0; duration_in = '0; voice_done = '0;
      tick();
      // note_ready must stay low while reset is high even with a request offered
      note_valid = 1'b1; note_in = 6'd33; duration_in = 6'd3;
      #1;
      chk("ready_in_reset", 32'(note_ready), 32'd0);
      tick();
      chk("rst_load", 32'(load_voice), 32'd0);
      chk("rst_note", 32'(note_out), 32'd0);
      chk("rst_dur", 32'(duration_out), 32'd0);
      chk("rst_busy", 32'(voice_busy), 32'd0);

      // First note after reset
      reset = 1'b0; note_in = 6'd12; duration_in = 6'd4;
      #1;
      chk("first_ready", 32'(note_ready), 32'd1);
      tick();
      note_valid = 1'b0;
      chk("first_load", 32'(load_voice), 32'b001);
      chk("first_note", 32'(note_out), 32'd12);
      chk("first_dur", 32'(duration_out), 32'd4);
      chk("first_busy", 32'(voice_busy), 32'b001);
      chk("load_ready", 32'(note_ready), 32'd0);
      tick();
      chk("hold_load", 32'(load_voice), 32'd0);
      chk("hold_ready", 32'(note_ready), 32'd0);
      tick();
      chk("idle_ready", 32'(note_ready), 32'd1);

      // Rest: handshake completes, nothing loads, buses unchanged
      note_valid = 1'b1; note_in = 6'd0; duration_in = 6'd8;
      tick();
      note_valid = 1'b0;
      chk("rest_load", 32'(load_voice), 32'd0);
      chk("rest_note", 32'(note_out), 32'd12);
      chk("rest_dur", 32'(duration_out), 32'd4);
      chk("rest_ready", 32'(note_ready), 32'd1);
      chk("rest_busy", 32'(voice_busy), 32'b001);
      tick();
      chk("rest_load2", 32'(load_voice), 32'd0);

      // Three back-to-back notes fill voices 0,1,2 on a 3-cycle cadence
      do_reset();
      note_valid = 1'b1; duration_in = 6'd1;
      for (int i = 0; i < 3; i++) begin
         note_in = 6'(10 * (i + 1));
         #1;
         chk("b2b_ready", 32'(note_ready), 32'd1);
         tick();
         chk("b2b_load", 32'(load_voice), 32'(1 << i));
         chk("b2b_note", 32'(note_out), 32'(10 * (i + 1)));
         tick();
         chk("b2b_hold", 32'(load_voice), 32'd0);
         tick();
      end
      chk("b2b_busy", 32'(voice_busy), 32'b111);

`ifndef VOICE_STEAL_EN
      // Fourth note stalls until voice 0 reports done
      note_in = 6'd40; duration_in = 6'd0;
      #1;
      chk("full_ready", 32'(note_ready), 32'd0);
      tick();
      chk("full_ready2", 32'(note_ready), 32'd0);
      chk("full_load", 32'(load_voice), 32'd0);
      voice_done = 3'b001;
      tick();
      voice_done = 3'b000;
      chk("freed_busy", 32'(voice_busy), 32'b110);
      chk("freed_ready", 32'(note_ready), 32'd1);
      tick();
      note_valid = 1'b0;
      chk("v0_reload", 32'(load_voice), 32'b001);
      chk("v0_note", 32'(note_out), 32'd40);
      // Duration-0 voice asserts done immediately; ignored through LOAD/HOLD
      voice_done = 3'b001;
      tick();
      chk("done_ign_load", 32'(voice_busy), 32'b111);
      tick();
      chk("done_ign_hold", 32'(voice_busy), 32'b111);
      tick();
      chk("done_after_hold", 32'(voice_busy), 32'b110);
      voice_done = 3'b000;
`else
      // All busy: steal the oldest (voice 0), then the next oldest (voice 1)
      note_in = 6'd40;
      #1;
      chk("steal_ready", 32'(note_ready), 32'd1);
      tick();
      chk("steal4_load", 32'(load_voice), 32'b001);
      chk("steal4_busy", 32'(voice_busy), 32'b111);
      tick();
      tick();
      note_in = 6'd50;
      tick();
      note_valid = 1'b0;
      chk("steal5_load", 32'(load_voice), 32'b010);
      chk("steal5_note", 32'(note_out), 32'd50);
`endif

      // Reset during LOAD cancels the pulse
      do_reset();
      note_valid = 1'b1; note_in = 6'd5; duration_in = 6'd2;
      tick();
      note_valid = 1'b0;
      chk("pre_rst_load", 32'(load_voice), 32'b001);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      #1;
      chk("post_rst_load", 32'(load_voice), 32'd0);
      chk("post_rst_busy", 32'(voice_busy), 32'd0);
      chk("post_rst_ready", 32'(note_ready), 32'd1);
      tick();
      chk("post_rst_load2", 32'(load_voice), 32'd0);

      // play_enable dropped mid-sequence: LOAD/HOLD complete, busy frozen
      note_valid = 1'b1; note_in = 6'd7; duration_in = 6'd3;
      tick();
      note_valid = 1'b0;
      play_enable = 1'b0;
      #1;
      chk("pe_load_completes", 32'(load_voice), 32'b001);
      tick();
      tick();
      voice_done = 3'b001;
      note_valid = 1'b1; note_in = 6'd9;
      #1;
      chk("pe_ready", 32'(note_ready), 32'd0);
      tick();
      chk("pe_busy_frozen", 32'(voice_busy), 32'b001);
      chk("pe_no_load", 32'(load_voice), 32'd0);
      voice_done = 3'b000;
      play_enable = 1'b1;
      #1;
      chk("pe_back_idle", 32'(note_ready), 32'd1);
      tick();
      note_valid = 1'b0;
      chk("pe_load_v1", 32'(load_voice), 32'b010);
      chk("pe_busy_after", 32'(voice_busy), 32'b011);
      chk("pe_note", 32'(note_out), 32'd9);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
